// File: rtl/cpu_pkg.sv
// Shared types and constants for the front-end pipeline stages.
// Optional halt detection in fetch_stage is enabled with FETCH_HALT_EN.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_OPCODE = 32'hFFFF_FFFF;
  localparam int PC_INC = 4;

  typedef enum logic [1:0] {
    RUN,
    STALLED,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding the instruction that was in flight
// when a stall arrived.
module fetch_skid
  import cpu_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [AW-1:0]      load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [AW-1:0]      pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, synchronous imem requests and a stall skid buffer.
// Define FETCH_HALT_EN to stop fetching when HALT_OPCODE is presented.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W      = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               halted
);

  fetch_state_t state, state_next;

  logic [ADDR_W-1:0]  pc;
  logic               req_valid;
  logic [ADDR_W-1:0]  req_pc;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  logic redirect;
  logic halt_hit;
  logic fetch;
  logic take_mem;
  logic take_skid;
  logic skid_load;
  logic skid_drain;
  logic skid_clear;

  assign redirect  = branch_taken | flush;
  assign imem_addr = pc;
  assign imem_en   = fetch & rst_n;

`ifdef FETCH_HALT_EN
  assign halt_hit = instr_valid && (instr == HALT_OPCODE);
`else
  logic unused_halt;
  assign unused_halt = ^HALT_OPCODE;
  assign halt_hit    = 1'b0;
`endif

  always_comb begin
    state_next = state;
    fetch      = 1'b0;
    take_mem   = 1'b0;
    take_skid  = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;
    if (redirect) begin
      state_next = RUN;
      skid_clear = 1'b1;
    end else if (halt_hit) begin
      state_next = HALTED;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (stall) begin
            state_next = STALLED;
            skid_load  = req_valid;
          end else begin
            fetch    = 1'b1;
            take_mem = 1'b1;
          end
        end
        STALLED: begin
          if (!stall) begin
            state_next = RUN;
            fetch      = 1'b1;
            take_skid  = 1'b1;
            skid_drain = 1'b1;
          end
        end
        HALTED: state_next = HALTED;
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      req_valid   <= 1'b0;
      req_pc      <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state     <= state_next;
      req_valid <= fetch;
      if (branch_taken) begin
        pc <= {branch_target[ADDR_W-1:2], 2'b00};
      end else if (fetch) begin
        pc <= pc + ADDR_W'(PC_INC);
      end
      if (fetch) begin
        req_pc <= pc;
      end
      if (redirect || halt_hit) begin
        instr_valid <= 1'b0;
      end else if (take_mem) begin
        instr       <= imem_data;
        instr_pc    <= req_pc;
        instr_valid <= req_valid;
      end else if (take_skid) begin
        instr       <= skid_instr;
        instr_pc    <= skid_pc;
        instr_valid <= skid_valid;
      end
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (redirect) begin
      halted <= 1'b0;
    end else if (halt_hit) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

  fetch_skid #(
    .AW(ADDR_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (skid_clear),
    .load_instr(imem_data),
    .load_pc   (req_pc),
    .valid     (skid_valid),
    .instr     (skid_instr),
    .pc        (skid_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run
// checked against an in-order fetch/present stream model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  logic        halt_on = 1'b0;
  logic [31:0] halt_addr = 32'h10;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_on && a == halt_addr) return HALT;
    return {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_data <= mem_word(imem_addr);
  end

  // Reference: every issued fetch joins an in-order queue and must be
  // presented exactly once, two cycles after issue at the earliest.
  typedef struct {
    logic [31:0] pc;
    int          t;
  } ent_t;

  ent_t        q[$];
  int          now = 0;
  logic [31:0] fptr = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic        m_halted = 1'b0;
  logic        prev_hold = 1'b0;

  always @(negedge clk) begin
    logic exp_v, hit, redir, exp_en;
    if (!rst_n) begin
      n_cmp++;
      if ({instr, instr_pc, instr_valid, halted, imem_en} !== 67'd0) begin
        n_err++;
        $display("FAIL mon_reset: instr=%h pc=%h v=%b h=%b en=%b, want all 0",
                 instr, instr_pc, instr_valid, halted, imem_en);
      end
      q.delete();
      now = 0;
      fptr = 32'h0;
      m_valid = 1'b0;
      m_halted = 1'b0;
      prev_hold = 1'b0;
    end else begin
      now++;
      if (!prev_hold) begin
        exp_v = (q.size() > 0) && (q[0].t <= now - 2);
        if (exp_v) begin
          m_pc = q[0].pc;
          void'(q.pop_front());
        end
        m_valid = exp_v;
      end
      n_cmp++;
      if (instr_valid !== m_valid) begin
        n_err++;
        $display("FAIL mon_valid t=%0d: got %b want %b", now, instr_valid, m_valid);
      end
      if (m_valid) begin
        n_cmp++;
        if (instr_pc !== m_pc || instr !== mem_word(m_pc)) begin
          n_err++;
          $display("FAIL mon_instr t=%0d: got pc=%h instr=%h want pc=%h instr=%h",
                   now, instr_pc, instr, m_pc, mem_word(m_pc));
        end
      end
      n_cmp++;
      if (halted !== m_halted) begin
        n_err++;
        $display("FAIL mon_halted t=%0d: got %b want %b", now, halted, m_halted);
      end
`ifdef FETCH_HALT_EN
      hit = m_valid && (mem_word(m_pc) == HALT);
`else
      hit = 1'b0;
`endif
      redir = branch_taken | flush;
      exp_en = !redir && !stall && !m_halted && !hit;
      n_cmp++;
      if (imem_en !== exp_en || imem_addr !== fptr) begin
        n_err++;
        $display("FAIL mon_fetch t=%0d: got en=%b addr=%h want en=%b addr=%h",
                 now, imem_en, imem_addr, exp_en, fptr);
      end
      if (redir) begin
        q.delete();
        m_halted = 1'b0;
        if (branch_taken) fptr = {branch_target[31:2], 2'b00};
      end else if (hit) begin
        q.delete();
        m_halted = 1'b1;
      end else if (exp_en) begin
        q.push_back('{fptr, now});
        fptr = fptr + 32'd4;
      end
      prev_hold = stall && !redir && !hit;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    stall = 1'b0;
    flush = 1'b0;
    branch_taken = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    stall = 1'b0;
    flush = 1'b0;
    branch_taken = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({instr, instr_pc, instr_valid, halted, imem_en} !== 67'd0 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_vals: instr=%h pc=%h v=%b h=%b en=%b addr=%h, want 0",
               instr, instr_pc, instr_valid, halted, imem_en, imem_addr);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (imem_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_en: got %b want 1", imem_en);
    end
    nxt();
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_c1: valid got %b want 0", instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      nxt();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== 32'(i) || instr_pc !== 32'(4 * i)) begin
        n_err++;
        $display("FAIL reset_stream c%0d: v=%b instr=%h pc=%h want 1 %h %h",
                 i + 2, instr_valid, instr, instr_pc, i, 4 * i);
      end
    end
  endtask

  task automatic test_stall();
    reset_dut();
    repeat (3) nxt();
    stall = 1'b1;
    #1;
    n_cmp++;
    if (imem_en !== 1'b0) begin
      n_err++;
      $display("FAIL stall_en: got %b want 0", imem_en);
    end
    for (int k = 0; k < 3; k++) begin
      nxt();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== 32'h1) begin
        n_err++;
        $display("FAIL stall_hold %0d: v=%b pc=%h instr=%h want 1 4 1",
                 k, instr_valid, instr_pc, instr);
      end
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nxt();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(8 + 4 * k) || instr !== 32'(2 + k)) begin
        n_err++;
        $display("FAIL stall_resume %0d: v=%b pc=%h instr=%h want 1 %h %h",
                 k, instr_valid, instr_pc, instr, 8 + 4 * k, 2 + k);
      end
    end
  endtask

  // Stall raised together with the branch: the redirect must win.
  task automatic test_branch();
    reset_dut();
    repeat (5) nxt();
    branch_taken = 1'b1;
    branch_target = 32'h103;
    stall = 1'b1;
    nxt();
    branch_taken = 1'b0;
    stall = 1'b0;
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL branch_bubble1: valid got %b want 0", instr_valid);
    end
    nxt();
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL branch_bubble2: valid got %b want 0", instr_valid);
    end
    for (int k = 0; k < 2; k++) begin
      nxt();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(256 + 4 * k) || instr !== 32'(64 + k)) begin
        n_err++;
        $display("FAIL branch_target %0d: v=%b pc=%h instr=%h want 1 %h %h",
                 k, instr_valid, instr_pc, instr, 256 + 4 * k, 64 + k);
      end
    end
  endtask

  task automatic test_flush_stall();
    reset_dut();
    repeat (3) nxt();
    stall = 1'b1;
    nxt();
    nxt();
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    stall = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'hC || imem_en !== 1'b1) begin
      n_err++;
      $display("FAIL flush_stall: v=%b addr=%h en=%b want 0 c 1",
               instr_valid, imem_addr, imem_en);
    end
    nxt();
    nxt();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hC || instr !== 32'h3) begin
      n_err++;
      $display("FAIL flush_resume: v=%b pc=%h instr=%h want 1 c 3",
               instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want_pc[2];
    logic [31:0] want_in[2];
    want_pc[0] = 32'hFFFF_FFFC;
    want_pc[1] = 32'h0;
    want_in[0] = 32'h3FFF_FFFF;
    want_in[1] = 32'h0;
    reset_dut();
    repeat (2) nxt();
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    nxt();
    branch_taken = 1'b0;
    nxt();
    for (int k = 0; k < 2; k++) begin
      nxt();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr_pc !== want_pc[k] || instr !== want_in[k]) begin
        n_err++;
        $display("FAIL wrap %0d: v=%b pc=%h instr=%h want 1 %h %h",
                 k, instr_valid, instr_pc, instr, want_pc[k], want_in[k]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    repeat (3) nxt();
    stall = 1'b1;
    nxt();
    nxt();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_en !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_vals: v=%b en=%b want 0 0", instr_valid, imem_en);
    end
    nxt();
    rst_n = 1'b1;
    stall = 1'b0;
    nxt();
    nxt();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0) begin
      n_err++;
      $display("FAIL midreset_first: v=%b pc=%h instr=%h want 1 0 0",
               instr_valid, instr_pc, instr);
    end
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    halt_on = 1'b1;
    halt_addr = 32'h10;
    reset_dut();
    repeat (6) nxt();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== HALT) begin
      n_err++;
      $display("FAIL halt_word: v=%b pc=%h instr=%h want 1 10 %h",
               instr_valid, instr_pc, instr, HALT);
    end
    for (int k = 0; k < 4; k++) begin
      nxt();
      n_cmp++;
      if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_en !== 1'b0) begin
        n_err++;
        $display("FAIL halt_hold %0d: h=%b v=%b en=%b want 1 0 0",
                 k, halted, instr_valid, imem_en);
      end
    end
    branch_taken = 1'b1;
    branch_target = 32'h20;
    nxt();
    branch_taken = 1'b0;
    #1;
    n_cmp++;
    if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 32'h20) begin
      n_err++;
      $display("FAIL halt_exit: h=%b en=%b addr=%h want 0 1 20",
               halted, imem_en, imem_addr);
    end
    nxt();
    nxt();
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== 32'h8) begin
      n_err++;
      $display("FAIL halt_resume: v=%b pc=%h instr=%h want 1 20 8",
               instr_valid, instr_pc, instr);
    end
    halt_on = 1'b0;
  endtask
`endif

  task automatic test_random();
    int start;
    reset_dut();
    start = n_err;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 99) < 3);
      branch_taken = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 3) == 0) branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else branch_target = $urandom;
      nxt();
    end
    stall = 1'b0;
    flush = 1'b0;
    branch_taken = 1'b0;
    repeat (4) nxt();
    n_cmp++;
    if (instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL random_steady: valid got %b want 1 (errs in run %0d)",
               instr_valid, n_err - start);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_flush_stall();
    test_wrap();
    test_reset_mid_stall();
`ifdef FETCH_HALT_EN
    test_halt();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
